// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit for the multi-cycle RV32I core.
// Checks alignment and funct3 legality, drives a request/grant/response
// data bus with a timeout, and returns extended load data with a done pulse.
module rv32i_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [1:0]      err_code_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 of the limit is enough.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             store_q;

  logic             illegal;
  logic             misaligned;
  logic [3:0]       be_next;
  logic [XLEN-1:0]  wdata_next;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [XLEN-1:0]  ext_data;

  // Decode the incoming request: legality, alignment, enables and lane data.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b0000;
    wdata_next = '0;
    if (is_store_i) begin
      illegal = funct3_i[2] | (funct3_i[1:0] == 2'b11);
    end else begin
      illegal = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
    end
    case (funct3_i[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_next    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata_i[15:0]}};
        misaligned = addr_i[0];
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
        misaligned = |addr_i[1:0];
      end
    endcase
    if (!is_store_i) begin
      wdata_next = '0;
    end
  end

  // Pick the addressed lane out of the read data and extend it per funct3.
  always_comb begin
    lane_byte = 8'h00;
    lane_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ext_data  = '0;
    case (off_q)
      2'd0:    lane_byte = mem_rdata_i[7:0];
      2'd1:    lane_byte = mem_rdata_i[15:8];
      2'd2:    lane_byte = mem_rdata_i[23:16];
      default: lane_byte = mem_rdata_i[31:24];
    endcase
    case (f3_q)
      3'b000:  ext_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  ext_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  ext_data = mem_rdata_i;
      3'b100:  ext_data = {24'h000000, lane_byte};
      3'b101:  ext_data = {16'h0000, lane_half};
      default: ext_data = '0;
    endcase
  end

  // Access FSM: all bus and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      store_q     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_code_o  <= ERR_OK;
      load_data_o <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (illegal) begin
              done_o      <= 1'b1;
              err_code_o  <= ERR_ILLEGAL;
              load_data_o <= '0;
            end else if (misaligned) begin
              done_o      <= 1'b1;
              err_code_o  <= ERR_MISALIGN;
              load_data_o <= '0;
            end else begin
              state       <= REQ;
              busy_o      <= 1'b1;
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store_i;
              mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
              mem_be_o    <= be_next;
              mem_wdata_o <= wdata_next;
              f3_q        <= funct3_i;
              off_q       <= addr_i[1:0];
              store_q     <= is_store_i;
              tmo_cnt     <= '0;
            end
          end
        end
        REQ, RSP: begin
          if (mem_rvalid_i && (state == RSP || mem_gnt_i)) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            done_o      <= 1'b1;
            err_code_o  <= ERR_OK;
            load_data_o <= store_q ? '0 : ext_data;
          end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            done_o      <= 1'b1;
            err_code_o  <= ERR_TIMEOUT;
            load_data_o <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (state == REQ && mem_gnt_i) begin
              state     <= RSP;
              mem_req_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: table-driven and randomized checks of rv32i_lsu against a
// transaction-level reference model of the load/store rules.
module tb_rv32i_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_code_o;
  logic [31:0] load_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int errors = 0;
  int checks = 0;

  rv32i_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_code_o(err_code_o),
    .load_data_o(load_data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          b2b;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          r;
    logic [1:0]  err;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wd;
    int          kdone;
  } vec_t;

  vec_t vecs[17];

  // Advance to the next cycle; outputs are read and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input bit st, input logic [2:0] f3);
    if (st) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    int off;
    be = 4'b0000;
    off = int'(addr % 4);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size_of(f3));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++)
      res = res | (((wdata >> (8 * (i % size_of(f3)))) & 32'hFF) << (8 * i));
    return res;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    longint v;
    int nbits;
    nbits = 8 * size_of(f3);
    v = longint'(rdata >> (8 * (addr % 4)));
    if (nbits < 32) begin
      v = v % (longint'(1) << nbits);
      if (!f3[2] && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    end
    return v[31:0];
  endfunction

  // Issue one access in the current cycle and play the bus with grant after g cycles, rvalid r cycles later.
  task automatic applyStimulus(input string name, input bit st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                               input int g, input int r, input logic [1:0] exp_err, input logic [31:0] exp_data,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_kdone);
    start_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    mem_rdata_i = rdata; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int k = 0; k <= exp_kdone; k++) begin
      if (k == exp_kdone) begin
        checkOutput($sformatf("%s.done", name), 32'(done_o), 32'd1);
        checkOutput($sformatf("%s.err", name), 32'(err_code_o), 32'(exp_err));
        checkOutput($sformatf("%s.data", name), load_data_o, exp_data);
        checkOutput($sformatf("%s.req_end", name), 32'(mem_req_o), 32'd0);
        checkOutput($sformatf("%s.busy_end", name), 32'(busy_o), 32'd0);
      end else begin
        checkOutput($sformatf("%s.nodone%0d", name, k), 32'(done_o), 32'd0);
        checkOutput($sformatf("%s.busy%0d", name, k), 32'(busy_o), 32'd1);
        checkOutput($sformatf("%s.req%0d", name, k), 32'(mem_req_o), 32'(k <= g));
        if (k <= g) begin
          checkOutput($sformatf("%s.addr%0d", name, k), mem_addr_o, addr & 32'hFFFF_FFFC);
          checkOutput($sformatf("%s.we%0d", name, k), 32'(mem_we_o), 32'(st));
          checkOutput($sformatf("%s.be%0d", name, k), 32'(mem_be_o), 32'(exp_be));
          checkOutput($sformatf("%s.wd%0d", name, k), mem_wdata_o, exp_wd);
        end
        mem_gnt_i = (k == g);
        mem_rvalid_i = (k == g + r);
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
      end
    end
  endtask

  initial begin
    //         b2b st f3      addr          wdata         rdata         g   r  err    data          be       wd            kdone
    vecs[0]  = '{0, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,  0, 2'b00, 32'hFFFF_FF80, 4'b1000, 32'h0,        1};
    vecs[1]  = '{0, 0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,  0, 2'b00, 32'h0000_0080, 4'b1000, 32'h0,        1};
    vecs[2]  = '{0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        3,  2, 2'b00, 32'h0,         4'b1100, 32'hABCD_ABCD, 6};
    vecs[3]  = '{0, 0, 3'b010, 32'h0000_1002, 32'h0,        32'h0,         0,  0, 2'b01, 32'h0,         4'b0000, 32'h0,        0};
    vecs[4]  = '{0, 0, 3'b011, 32'h0000_1000, 32'h0,        32'h0,         0,  0, 2'b10, 32'h0,         4'b0000, 32'h0,        0};
    vecs[5]  = '{0, 1, 3'b011, 32'h0000_1001, 32'h0,        32'h0,         0,  0, 2'b10, 32'h0,         4'b0000, 32'h0,        0};
    vecs[6]  = '{0, 0, 3'b010, 32'h0000_4000, 32'h0,        32'h55AA_55AA, 99, 0, 2'b11, 32'h0,         4'b1111, 32'h0,        8};
    vecs[7]  = '{0, 1, 3'b010, 32'h0000_5004, 32'h1234_5678, 32'h0,        0,  1, 2'b00, 32'h0,         4'b1111, 32'h1234_5678, 2};
    vecs[8]  = '{1, 0, 3'b010, 32'h0000_6008, 32'h0,        32'hDEAD_BEEF, 1,  0, 2'b00, 32'hDEAD_BEEF, 4'b1111, 32'h0,        2};
    vecs[9]  = '{0, 0, 3'b001, 32'h0000_7002, 32'h0,        32'h8001_0000, 0,  0, 2'b00, 32'hFFFF_8001, 4'b1100, 32'h0,        1};
    vecs[10] = '{0, 0, 3'b100, 32'h0000_8001, 32'h0,        32'h0000_AB00, 4,  3, 2'b00, 32'h0000_00AB, 4'b0010, 32'h0,        8};
    vecs[11] = '{0, 0, 3'b010, 32'h0000_8000, 32'h0,        32'h1111_1111, 7,  1, 2'b11, 32'h0,         4'b1111, 32'h0,        8};
    vecs[12] = '{0, 1, 3'b000, 32'h0000_9002, 32'h0000_00C3, 32'h0,        2,  0, 2'b00, 32'h0,         4'b0100, 32'hC3C3_C3C3, 3};
    vecs[13] = '{0, 1, 3'b100, 32'h0000_9000, 32'h0,        32'h0,         0,  0, 2'b10, 32'h0,         4'b0000, 32'h0,        0};
    vecs[14] = '{0, 0, 3'b111, 32'h0000_9000, 32'h0,        32'h0,         0,  0, 2'b10, 32'h0,         4'b0000, 32'h0,        0};
    vecs[15] = '{0, 0, 3'b001, 32'h0000_1001, 32'h0,        32'h0,         0,  0, 2'b01, 32'h0,         4'b0000, 32'h0,        0};
    vecs[16] = '{0, 0, 3'b101, 32'h0000_9003, 32'h0,        32'h0,         0,  0, 2'b01, 32'h0,         4'b0000, 32'h0,        0};

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst.busy", 32'(busy_o), 32'd0);
    checkOutput("rst.done", 32'(done_o), 32'd0);
    checkOutput("rst.req", 32'(mem_req_o), 32'd0);
    checkOutput("rst.err", 32'(err_code_o), 32'd0);
    checkOutput("rst.data", load_data_o, 32'd0);
    checkOutput("rst.addr", mem_addr_o, 32'd0);
    checkOutput("rst.be", 32'(mem_be_o), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (!vecs[i].b2b) begin
        tick();
        checkOutput($sformatf("v%0d.idle_nodone", i), 32'(done_o), 32'd0);
      end
      applyStimulus($sformatf("v%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].g, vecs[i].r, vecs[i].err, vecs[i].data,
                    vecs[i].be, vecs[i].wd, vecs[i].kdone);
    end

    // Late acknowledge after a timeout must not produce a completion.
    tick();
    applyStimulus("tmo", 1'b0, 3'b010, 32'h0000_A000, 32'h0, 32'h0, 50, 0, 2'b11, 32'h0, 4'b1111, 32'h0, TMO);
    tick();
    mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1;
    checkOutput("late.nodone0", 32'(done_o), 32'd0);
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    checkOutput("late.nodone1", 32'(done_o), 32'd0);
    checkOutput("late.busy", 32'(busy_o), 32'd0);
    checkOutput("late.req", 32'(mem_req_o), 32'd0);
    checkOutput("late.err_hold", 32'(err_code_o), 32'd3);
    tick();
    checkOutput("late.nodone2", 32'(done_o), 32'd0);

    // Reset while waiting for the response aborts the access.
    start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_3000;
    tick();
    start_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    checkOutput("rsp.busy", 32'(busy_o), 32'd1);
    checkOutput("rsp.req", 32'(mem_req_o), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst.busy", 32'(busy_o), 32'd0);
    checkOutput("midrst.req", 32'(mem_req_o), 32'd0);
    checkOutput("midrst.done", 32'(done_o), 32'd0);
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    checkOutput("midrst.nodone", 32'(done_o), 32'd0);
    applyStimulus("lhu", 1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'h8001_5A5A, 0, 0,
                  2'b00, 32'h0000_8001, 4'b1100, 32'h0, 1);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 80; n++) begin
      bit          st, b2b, legal, mis, done_ok;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata, exp_data, exp_wd;
      logic [1:0]  exp_err;
      logic [3:0]  exp_be;
      int          g, r, kdone;
      st = 1'(($urandom_range(0, 1)));
      b2b = ($urandom_range(0, 3) == 0);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr - (addr % 32'(size_of(f3) > 4 ? 4 : size_of(f3)));
      wdata = $urandom;
      rdata = $urandom;
      g = $urandom_range(0, 9);
      r = $urandom_range(0, 3);
      legal = is_legal(st, f3);
      mis = legal && is_misaligned(f3, addr);
      done_ok = (g + r) <= (TMO - 1);
      exp_be = model_be(f3, addr);
      exp_wd = st ? model_wdata(f3, wdata) : 32'h0;
      exp_data = 32'h0;
      if (!legal) begin
        exp_err = 2'b10; kdone = 0;
      end else if (mis) begin
        exp_err = 2'b01; kdone = 0;
      end else if (done_ok) begin
        exp_err = 2'b00; kdone = g + r + 1;
        if (!st) exp_data = model_load(f3, addr, rdata);
      end else begin
        exp_err = 2'b11; kdone = TMO;
      end
      if (!b2b) begin
        tick();
        checkOutput($sformatf("r%0d.idle_nodone", n), 32'(done_o), 32'd0);
      end
      applyStimulus($sformatf("r%0d", n), st, f3, addr, wdata, rdata, g, r,
                    exp_err, exp_data, exp_be, exp_wd, kdone);
    end

    tick();
    checkOutput("final.nodone", 32'(done_o), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
Load/store unit for the multi-cycle RV32I core. It sits between the EXECUTE/MEM_WAIT states of the core control FSM and the data-memory bus. It takes the ALU-computed effective address, funct3 and store data, and checks alignment and funct3 legality. It then generates byte enables and lane-replicated write data, runs a request/grant/response handshake with a timeout, and returns sign- or zero-extended load data with a single-cycle completion pulse.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
TIMEOUT_CYCLES, 255, maximum number of cycles spent in REQ+RSP before the access is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  one-cycle access request; honoured only in IDLE.
is_store_i  input  1  1 = store, 0 = load; sampled with start_i.
funct3_i  input  3  load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
addr_i  input  32  byte effective address.
wdata_i  input  32  store data (rs2).
busy_o  output  1  high while state is REQ or RSP.
done_o  output  1  one-cycle completion pulse.
err_code_o  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid when done_o=1.
load_data_o  output  32  extended load result; valid when done_o=1.
mem_req_o  output  1  bus request.
mem_we_o  output  1  bus write enable.
mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}.
mem_be_o  output  4  byte enables.
mem_wdata_o  output  32  lane-replicated write data.
mem_gnt_i  input  1  request accepted.
mem_rvalid_i  input  1  response/ack (for both loads and stores).
mem_rdata_i  input  32  read data, valid with rvalid.

Behaviour:
- Reset: state=IDLE, all outputs 0, timeout counter 0. Reset mid-access aborts the access: mem_req_o low after the edge, no done_o.
- Internal states: IDLE, REQ, RSP. All outputs are registered.
- IDLE + start_i, legality check:
  - Illegal funct3: loads 011/110/111; stores ≥011.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
  - On error: stay in IDLE, no bus activity. Next cycle done_o=1, err_code_o=10 (illegal) or 01 (misaligned), load_data_o=0. Illegal takes priority over misaligned.
- Legal start: latch the request and go to REQ. From the next cycle, mem_req_o=1 and mem_addr/we/be/wdata are stable until grant.
- Byte enables:
  - Byte: be = 4'b0001 << addr[1:0].
  - Half: be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
  - The same enables are used for loads.
- Write data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes wdata unchanged. For loads, mem_wdata_o=0.
- REQ:
  - mem_gnt_i=1 → mem_req_o drops next cycle and the FSM enters RSP.
  - mem_gnt_i and mem_rvalid_i both 1 in the same cycle → complete immediately.
- RSP: on mem_rvalid_i, complete.
- Completion: state goes to IDLE; done_o=1 on the next cycle with err_code_o=00.
  - Loads: load_data_o is the selected lane, extended. LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores: load_data_o=0.
- Minimum latency: start at cycle T; req at T+1; gnt+rvalid at T+1; done at T+2.
- Timeout:
  - Counter clears on accepted start and increments each cycle spent in REQ/RSP.
  - If the count reaches TIMEOUT_CYCLES-1 without completion, abort: mem_req_o drops, state goes to IDLE, and done_o fires next cycle with err_code_o=11 and load_data_o=0.
  - Completion in the same cycle as the timeout threshold wins.
- mem_rvalid_i/mem_gnt_i received in IDLE (late ack after an abort) are ignored.
- start_i while busy is ignored. start_i in the cycle done_o=1 is accepted.
- done_o is never asserted for two consecutive cycles except for back-to-back accepted accesses.
- load_data_o and err_code_o hold their values until the next done_o.

Test Plan:
- LB addr 0x1003, rdata 0x80FF1234, gnt+rvalid at first req cycle → be=1000, done at T+2, load_data=0xFFFFFF80, err=00. LBU at the same address → 0x00000080.
- SH addr 0x2002 wdata 0x0000ABCD, gnt delayed 3 cycles, rvalid 2 cycles later → mem_we=1, be=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000, signals stable during the stall, done exactly 1 cycle after rvalid.
- LW addr 0x1002 → no mem_req_o, done at T+1 with err=01. Load funct3=011 addr 0x1000 → err=10. SW funct3=011 misaligned → err=10.
- TIMEOUT_CYCLES=8, gnt never asserted → mem_req_o high for 8 cycles, done with err=11. A late rvalid afterwards produces no done_o.
- Assert rst in RSP → next cycle busy=0, mem_req=0, done=0. A new LHU at 0x3002 with rdata 0x8001xxxx → 0x00008001.
- Back-to-back: start an LW in the done_o cycle of the previous SW → accepted, second done_o correct, no lost or duplicate pulses.
